// File: rtl/hs_sync_sink_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hs_sync_pkg
// Description : Shared types and helpers for the hs_sync_sink pipeline exit
//               stage. Contains the handshake FSM state encoding, the width
//               of the optional statistics counters, and the FIFO pointer
//               width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package hs_sync_pkg;

    // Width of the optional token / stall statistics counters.
    localparam int STATS_W = 32;

    // Handshake FSM: IDLE waits for a synchronized request, ACK holds the
    // acknowledge high until the request has been withdrawn.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    // Pointer width for a circular buffer of 'depth' entries; never below 1
    // so that a declared vector always has at least one bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hs_sync_sink_if.sv
`default_nettype none
// ============================================================================
// Module      : hs_sync_sink_if
// Description : Bundles the 4-phase upstream handshake and the synchronous
//               valid/ready output stream of hs_sync_sink.
//   Lreq/Ldata/Lerr : request, bundled data and error tag from upstream
//   Lack            : 4-phase acknowledge back to upstream
//   out_valid/out_ready/out_data/out_err : synchronous output stream
//   level           : FIFO occupancy, 0..DEPTH
//   modport master  : upstream producer plus downstream consumer side
//   modport slave   : the sink itself
// Revision    : 1.0 - initial release
// ============================================================================
interface hs_sync_sink_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    logic               Lreq;
    logic               Lack;
    logic [WIDTH-1:0]   Ldata;
    logic               Lerr;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic               out_err;
    logic [$clog2(DEPTH):0] level;

    modport master (
        output Lreq, Ldata, Lerr, out_ready,
        input  Lack, out_valid, out_data, out_err, level
    );

    modport slave (
        input  Lreq, Ldata, Lerr, out_ready,
        output Lack, out_valid, out_data, out_err, level
    );
endinterface
`default_nettype wire

// File: rtl/hs_sync_sink_sync_ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_ff
// Description : Multi-flop single-bit synchronizer bringing an asynchronous
//               level into the clk domain. Asynchronous active-high reset
//               clears every stage.
//   clk  : destination clock
//   rst  : asynchronous active-high reset
//   i_d  : asynchronous input level
//   o_q  : synchronized output (STAGES flops later)
// Revision    : 1.0 - initial release
// ============================================================================
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/hs_sync_sink.sv
`default_nettype none
// ============================================================================
// Module      : hs_sync_sink
// Description : Pipeline exit stage. Terminates a 4-phase bundled-data
//               handshake, synchronizes the request into clk, captures
//               {Lerr, Ldata} into a circular FIFO and presents it as a
//               valid/ready stream.
//   clk        : sole clock, rising edge
//   rst        : asynchronous active-high reset
//   bus        : hs_sync_sink_if.slave (Lreq/Lack/Ldata/Lerr upstream,
//                out_valid/out_ready/out_data/out_err/level downstream)
//   tok_cnt    : (HS_SYNC_SINK_STATS_EN only) saturating push counter
//   stall_cnt  : (HS_SYNC_SINK_STATS_EN only) saturating full-stall counter
// Optional    : define HS_SYNC_SINK_STATS_EN to add the statistics outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module hs_sync_sink
    import hs_sync_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    hs_sync_sink_if.slave      bus
`ifdef HS_SYNC_SINK_STATS_EN
    ,
    output logic [STATS_W-1:0] tok_cnt,
    output logic [STATS_W-1:0] stall_cnt
`endif
);

    localparam int                 c_PTR_W = ptr_width(DEPTH);
    localparam int                 c_LVL_W = $clog2(DEPTH) + 1;
    localparam logic [c_LVL_W-1:0] c_FULL  = c_LVL_W'(DEPTH);

    // ------------------------------------------------------------------
    // Elaboration-time parameter sanity
    // ------------------------------------------------------------------
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("hs_sync_sink: DEPTH must be a power of 2 and at least 2");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("hs_sync_sink: SYNC_STAGES must be at least 2");
    end

    // ------------------------------------------------------------------
    // Request synchronizer: the only consumer of the raw Lreq
    // ------------------------------------------------------------------
    logic w_req_s;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk (clk),
        .rst (rst),
        .i_d (bus.Lreq),
        .o_q (w_req_s)
    );

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t             r_state;
    state_t             w_state_next;
    logic               r_lack;
    logic               w_lack_next;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_LVL_W-1:0] r_level;
    logic [WIDTH:0]     r_mem [DEPTH];

    logic w_full;
    logic w_valid;
    logic w_push;
    logic w_pop;
    logic w_stall;

    // Full is judged on the registered level, before any pop this cycle,
    // so a full FIFO being popped still refuses the push until next cycle.
    assign w_full  = (r_level == c_FULL);
    assign w_valid = (r_level != '0);
    assign w_pop   = w_valid && bus.out_ready;

    // ------------------------------------------------------------------
    // Handshake FSM: next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_lack_next  = r_lack;
        w_push       = 1'b0;
        w_stall      = 1'b0;
        case (r_state)
            IDLE: begin
                w_lack_next = 1'b0;
                if (w_req_s) begin
                    if (!w_full) begin
                        // Bundled data is already stable: the upstream
                        // timing constraint spans the synchronizer delay.
                        w_push       = 1'b1;
                        w_lack_next  = 1'b1;
                        w_state_next = ACK;
                    end else begin
                        w_stall = 1'b1;
                    end
                end
            end
            ACK: begin
                w_lack_next = 1'b1;
                if (!w_req_s) begin
                    w_lack_next  = 1'b0;
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_lack_next  = 1'b0;
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_lack  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_lack  <= w_lack_next;
        end
    end

    // ------------------------------------------------------------------
    // FIFO: pointers wrap naturally because DEPTH is a power of 2
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_LVL_W'(1);
                2'b01:   r_level <= r_level - c_LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage is cleared on reset so the head outputs read zero while empty
    // after reset without needing a gating mux on the read path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= {bus.Lerr, bus.Ldata};
        end
    end

    assign bus.Lack                   = r_lack;
    assign bus.out_valid              = w_valid;
    assign bus.level                  = r_level;
    assign {bus.out_err, bus.out_data} = r_mem[r_rd_ptr];

`ifdef HS_SYNC_SINK_STATS_EN
    // ------------------------------------------------------------------
    // Saturating statistics counters
    // ------------------------------------------------------------------
    logic [STATS_W-1:0] r_tok_cnt;
    logic [STATS_W-1:0] r_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tok_cnt   <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_push && (r_tok_cnt != '1)) begin
                r_tok_cnt <= r_tok_cnt + STATS_W'(1);
            end
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + STATS_W'(1);
            end
        end
    end

    assign tok_cnt   = r_tok_cnt;
    assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hs_sync_sink.sv
`default_nettype none
// ============================================================================
// Module      : tb_hs_sync_sink
// Description : Self-checking bench for hs_sync_sink. An upstream driver runs
//               the 4-phase handshake, a consumer process drives out_ready,
//               and a monitor compares every popped entry and the occupancy
//               against a token-queue / counting reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hs_sync_sink;
    import hs_sync_pkg::*;

    localparam int c_WIDTH = 8;
    localparam int c_DEPTH = 4;
    localparam int c_SYNC  = 2;
    localparam int c_LAT   = c_SYNC + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hs_sync_sink_if #(.WIDTH(c_WIDTH), .DEPTH(c_DEPTH)) bus ();

`ifdef HS_SYNC_SINK_STATS_EN
    logic [STATS_W-1:0] tok_cnt;
    logic [STATS_W-1:0] stall_cnt;
`endif

    hs_sync_sink #(
        .WIDTH       (c_WIDTH),
        .DEPTH       (c_DEPTH),
        .SYNC_STAGES (c_SYNC)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus)
`ifdef HS_SYNC_SINK_STATS_EN
        ,
        .tok_cnt   (tok_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    // ------------------------------------------------------------------
    // Bookkeeping
    // ------------------------------------------------------------------
    int n_tests = 0;
    int n_fail  = 0;

    logic [c_WIDTH:0] exp_q[$];     // {err, data} in send order
    logic [c_WIDTH:0] mon_exp;
    int   n_acked   = 0;            // tokens accepted (one per Lack rise)
    int   n_popped  = 0;
    int   n_out     = 0;
    logic prev_lack = 1'b0;

    // out_ready source: 0 low, 1 high, 2 toggle, 3 random, 4 manual
    int   ready_mode   = 0;
    logic ready_auto   = 1'b0;
    logic ready_manual = 1'b0;
    assign bus.out_ready = (ready_mode == 4) ? ready_manual : ready_auto;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       ready_auto = 1'b0;
            1:       ready_auto = 1'b1;
            2:       ready_auto = ~ready_auto;
            3:       ready_auto = 1'($urandom_range(0, 1));
            default: ready_auto = ready_auto;
        endcase
    end

    // Monitor on the falling edge: occupancy must equal accepted minus
    // popped tokens, and each pop must deliver the oldest unread token.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            n_acked   = 0;
            n_popped  = 0;
            prev_lack = 1'b0;
        end else begin
            if (bus.Lack && !prev_lack) n_acked++;
            prev_lack = bus.Lack;
            check("level", 64'(bus.level), 64'(n_acked - n_popped));
            check("out_valid", 64'(bus.out_valid), 64'((n_acked - n_popped) != 0));
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("pop_unexpected", 64'(1), 64'(0));
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("out_token", 64'({bus.out_err, bus.out_data}), 64'(mon_exp));
                end
                n_popped++;
                n_out++;
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver helpers (always entered at posedge + 1)
    // ------------------------------------------------------------------
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_lack(input logic val, input int budget, output int edges);
        edges = 0;
        while (bus.Lack !== val && edges < budget) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic send_token(input logic [c_WIDTH-1:0] data, input logic err);
        int e;
        bus.Ldata = data;
        bus.Lerr  = err;
        bus.Lreq  = 1'b1;
        exp_q.push_back({err, data});
        wait_lack(1'b1, 200, e);
        check("ack_rise", 64'(bus.Lack), 64'(1));
        bus.Lreq = 1'b0;
        wait_lack(1'b0, 50, e);
        check("ack_fall", 64'(bus.Lack), 64'(0));
    endtask

    task automatic drain();
        int c;
        ready_mode = 1;
        c = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && c < 200) begin
            tick(1);
            c++;
        end
        tick(2);
        check("drain_queue", 64'(exp_q.size()), 64'(0));
        check("drain_level", 64'(bus.level), 64'(0));
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        bus.Lreq = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(1);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        int e;
        int out0;
        int stall_w;
        bus.Lreq  = 1'b0;
        bus.Ldata = '0;
        bus.Lerr  = 1'b0;

        // Reset state
        tick(2);
        check("rst_lack",      64'(bus.Lack),      64'(0));
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_level",     64'(bus.level),     64'(0));
        check("rst_out_data",  64'(bus.out_data),  64'(0));
        check("rst_out_err",   64'(bus.out_err),   64'(0));
        rst = 1'b0;
        tick(2);

        // Single token: latency both ways
        ready_mode = 1;
        bus.Ldata  = 8'hA5;
        bus.Lerr   = 1'b0;
        bus.Lreq   = 1'b1;
        exp_q.push_back({1'b0, 8'hA5});
        wait_lack(1'b1, 20, e);
        check("lat_rise", 64'(e), 64'(c_LAT));
        bus.Lreq = 1'b0;
        wait_lack(1'b0, 20, e);
        check("lat_fall", 64'(e), 64'(c_LAT));
        drain();

        // Error tag follows its token
        send_token(8'h3C, 1'b1);
        send_token(8'h5A, 1'b0);
        drain();

        // Backpressure: fill, stall the 5th, release one slot
        do_reset();
        ready_mode   = 4;
        ready_manual = 1'b0;
        for (int i = 1; i <= 4; i++) send_token(8'(8'h10 + i), 1'(i & 1));
        tick(1);
        check("bp_full_level", 64'(bus.level), 64'(c_DEPTH));
        bus.Ldata = 8'h15;
        bus.Lerr  = 1'b1;
        bus.Lreq  = 1'b1;
        exp_q.push_back({1'b1, 8'h15});
        stall_w = 8;
        tick(stall_w);
        check("bp_stall_lack",  64'(bus.Lack),  64'(0));
        check("bp_stall_level", 64'(bus.level), 64'(c_DEPTH));
        ready_manual = 1'b1;
        tick(1);
        ready_manual = 1'b0;
        wait_lack(1'b1, 20, e);
        check("bp_release_lat", 64'(e), 64'(1));
        bus.Lreq = 1'b0;
        wait_lack(1'b0, 20, e);
        check("bp_ack_fall", 64'(bus.Lack), 64'(0));
`ifdef HS_SYNC_SINK_STATS_EN
        // Stalls: request seen synchronized from edge SYNC+1 through the
        // edge that pops (full is judged before the pop).
        check("stat_tok_cnt",   64'(tok_cnt),   64'(5));
        check("stat_stall_cnt", 64'(stall_cnt), 64'(stall_w + 1 - c_SYNC));
`endif
        drain();

        // Wrap-around with toggling ready
        out0       = n_out;
        ready_mode = 2;
        for (int i = 0; i < 12; i++) send_token(8'(i), 1'b0);
        drain();
        check("wrap_count", 64'(n_out - out0), 64'(12));

        // Reset mid-handshake
        do_reset();
        ready_mode = 0;
        send_token(8'h11, 1'b0);
        bus.Ldata = 8'h22;
        bus.Lerr  = 1'b0;
        bus.Lreq  = 1'b1;
        exp_q.push_back({1'b0, 8'h22});
        wait_lack(1'b1, 20, e);
        check("rm_pre_lack",  64'(bus.Lack),  64'(1));
        check("rm_pre_level", 64'(bus.level), 64'(2));
        rst      = 1'b1;
        bus.Lreq = 1'b0;
        #1;
        check("rm_async_lack",  64'(bus.Lack),      64'(0));
        check("rm_async_valid", 64'(bus.out_valid), 64'(0));
        check("rm_async_level", 64'(bus.level),     64'(0));
        tick(3);
        rst = 1'b0;
        tick(2);
        ready_mode = 1;
        send_token(8'h77, 1'b1);
        drain();

        // Randomized traffic
        ready_mode = 3;
        out0       = n_out;
        for (int i = 0; i < 30; i++) begin
            send_token(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            tick($urandom_range(0, 4));
        end
        drain();
        check("rand_count", 64'(n_out - out0), 64'(30));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/hs_sync_sink.md
Name: hs_sync_sink

Overview:
- Pipeline exit stage: terminates the 4-phase bundled-data handshake produced by the last asynchronous controller in a ring or linear pipeline.
- Converts each token into a synchronous valid/ready stream in the `clk` domain.
- Upstream drives `Lreq` with data bundled; this block synchronizes `Lreq`, captures data plus error tag into a small FIFO, and returns `Lack`.
- Used by benches and by synchronous consumers of the controller pipeline.

Parameters:
- WIDTH, 8, bundled data width.
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- SYNC_STAGES, 2, flops in the `Lreq` synchronizer; minimum 2.

Ports:
- clk  input  1  sole clock; all state rising-edge.
- rst  input  1  asynchronous, active-high reset.
- Lreq  input  1  4-phase request from upstream controller (asynchronous to `clk`).
- Lack  output  1  4-phase acknowledge to upstream; registered.
- Ldata  input  WIDTH  bundled data; stable from `Lreq` rise until `Lack` rise.
- Lerr  input  1  error tag bundled with `Ldata` (upstream Err detected for this token).
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts head entry.
- out_data  output  WIDTH  head entry data.
- out_err  output  1  head entry error tag.
- level  output  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (asynchronous, immediate):
  - `Lack`=0, FSM=IDLE, synchronizer flops=0, FIFO pointers=0, `level`=0.
  - `out_valid`=0; `out_data` and `out_err` = 0.
- Synchronizer: `req_s` = `Lreq` after SYNC_STAGES flops; no other logic touches raw `Lreq`.
- FSM states: IDLE, ACK.
  - IDLE: `Lack`=0. If `req_s`=1 and `level`<DEPTH: push {`Lerr`,`Ldata`} this cycle, `Lack`←1, go to ACK. If `req_s`=1 and full: stay in IDLE, no push (backpressure; upstream stalls).
  - ACK: `Lack`=1. When `req_s`=0: `Lack`←0, go to IDLE. No push in ACK.
- Data capture is sampled in the same cycle `req_s` is seen high. The bundling constraint covers the synchronizer delay.
- Latency:
  - `Lreq` rise to `Lack` rise: SYNC_STAGES+1 edges when not full.
  - `Lreq` fall to `Lack` fall: SYNC_STAGES+1 edges.
  - Minimum token period: 2*(SYNC_STAGES+1) cycles plus upstream delay.
  - Push to `out_valid`: 1 cycle (registered `level`).
- FIFO:
  - Circular buffer; pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - `level` ranges 0..DEPTH.
  - Pop occurs when `out_valid` && `out_ready`.
- Full condition is evaluated on registered `level` before the current cycle's pop. A full FIFO with a simultaneous pop does not accept a push that cycle; the push happens the next cycle.
- Simultaneous push and pop when 0<`level`<DEPTH: `level` unchanged, both pointers advance.
- Empty FIFO: `out_valid`=0. `out_ready` is ignored; no pop, no underflow.
- `out_data`/`out_err` reflect the head entry combinationally from storage.
- Reset mid-handshake: `Lack` drops immediately and queued tokens are discarded. After release the FSM restarts in IDLE. If `req_s` is still 1, the token is captured again. The system-wide reset makes upstream restart too, so this is defined and legal.

Optional Feature:
- Macro: `HS_SYNC_SINK_STATS_EN`.
- With the macro: adds outputs `tok_cnt` (32 bits) and `stall_cnt` (32 bits), both reset to 0.
  - `tok_cnt` increments on every push.
  - `stall_cnt` increments every cycle the FSM is in IDLE with `req_s`=1 and FIFO full.
  - Both counters saturate at all-ones.
- Without the macro: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package `hs_sync_pkg`: FSM state enum (IDLE, ACK), `STATS_W`=32, helper function for pointer width.
- Sub-module `sync_ff`: a SYNC_STAGES-deep single-bit synchronizer with asynchronous active-high `rst`; it is instantiated once for `Lreq`.
- FIFO storage stays inline.

Test Plan:
- Single token, `Ldata`=8'hA5, `Lerr`=0, `out_ready`=1:
  - `Lack` rises 3 edges after `Lreq` rises.
  - `out_valid` is 1 for one cycle with `out_data`=A5, `out_err`=0.
  - `Lack` falls 3 edges after `Lreq` falls.
- Error tag: token `Ldata`=8'h3C with `Lerr`=1 → `out_err`=1 with `out_data`=3C; the next token with `Lerr`=0 → `out_err`=0.
- Backpressure with `out_ready`=0:
  - Send 5 tokens → `level` reaches 4. The 5th `Lreq` stays high with `Lack`=0.
  - Raise `out_ready` for one cycle → 5th `Lack` rises on the following cycles.
  - Order popped is tokens 1..5.
- Wrap-around: 12 tokens 8'h00..8'h0B with `out_ready` toggling 1/0 → outputs are in order, `level` never exceeds 4, and no token is lost or duplicated.
- Reset mid-handshake: assert `rst` while `Lack`=1 and `level`=2 → `Lack`, `out_valid` and `level` go to 0 immediately, without waiting for a clock edge. After release with `Lreq` low, the next token is accepted normally.
- With `HS_SYNC_SINK_STATS_EN` defined: run the backpressure scenario → `tok_cnt`=5, and `stall_cnt` equals the number of full-stall cycles counted by the bench.
